// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: FSM states, RV32I opcodes and register-use helpers for hazard_ctrl
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_e;
  localparam logic [6:0] R_TYPE        = 7'b0110011;
  localparam logic [6:0] I_TYPE_LOAD   = 7'b0000011;
  localparam logic [6:0] I_TYPE_OP_IMM = 7'b0010011;
  localparam logic [6:0] S_TYPE        = 7'b0100011;
  localparam logic [6:0] B_TYPE        = 7'b1100011;
  localparam logic [6:0] JAL           = 7'b1101111;
  localparam logic [6:0] JALR          = 7'b1100111;
  function automatic logic reads_rs1(input logic [6:0] op);
    return op inside {R_TYPE, I_TYPE_LOAD, I_TYPE_OP_IMM, S_TYPE, B_TYPE, JALR};
  endfunction
  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {R_TYPE, S_TYPE, B_TYPE};
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-to-hazard-controller bundle; master = pipeline, slave = hazard_ctrl; perf ports under HAZARD_PERF_CNT_EN
interface hazard_ctrl_if;
  logic [31:0] instr_ID, instr_EX;
  logic [4:0]  rs1_raddr_ID, rs2_raddr_ID, rd_waddr_EX;
  logic        branch_taken_EX, dmem_req_M, dmem_ready;
  logic        stall_IF, stall_ID, stall_EX, stall_M, flush_IF, flush_EX, mem_timeout_err;
  logic [1:0]  state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
  modport master (
`ifdef HAZARD_PERF_CNT_EN
    input perf_stall_cnt, perf_flush_cnt,
`endif
    output instr_ID, instr_EX, rs1_raddr_ID, rs2_raddr_ID, rd_waddr_EX,
    output branch_taken_EX, dmem_req_M, dmem_ready,
    input stall_IF, stall_ID, stall_EX, stall_M, flush_IF, flush_EX, mem_timeout_err, state_o
  );
  modport slave (
`ifdef HAZARD_PERF_CNT_EN
    output perf_stall_cnt, perf_flush_cnt,
`endif
    input instr_ID, instr_EX, rs1_raddr_ID, rs2_raddr_ID, rd_waddr_EX,
    input branch_taken_EX, dmem_req_M, dmem_ready,
    output stall_IF, stall_ID, stall_EX, stall_M, flush_IF, flush_EX, mem_timeout_err, state_o
  );
endinterface

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: wrapping 32-bit counters of stalled-fetch cycles and redirect events; ports clk, rst, stall_i, redirect_i, stall_cnt_o, flush_cnt_o
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);
  logic [31:0] stall_q, flush_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + 32'(stall_i);
      flush_q <= flush_q + 32'(redirect_i);
    end
  end
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubble, branch squash and dmem freeze sequencing; ports clk, rst, bus (hazard_ctrl_if.slave); perf counters under HAZARD_PERF_CNT_EN
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.slave bus
);
  localparam logic [7:0] FLUSH_RELOAD = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT      = 8'(MEM_TIMEOUT);
  localparam state_e     REDIRECT_ST  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d, flush_cnt_q, flush_cnt_d;
  logic       ret_q, ret_d;
  logic       mem_stall, load_use, frozen, redirect, bubble;
  always_comb begin
    mem_stall = bus.dmem_req_M && !bus.dmem_ready;
    load_use  = bus.instr_EX[6:0] == I_TYPE_LOAD && bus.rd_waddr_EX != 5'd0 &&
                ((reads_rs1(bus.instr_ID[6:0]) && bus.rs1_raddr_ID == bus.rd_waddr_EX) ||
                 (reads_rs2(bus.instr_ID[6:0]) && bus.rs2_raddr_ID == bus.rd_waddr_EX));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      ret_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      ret_q       <= ret_d;
    end
  end
  // ret_q remembers that a memory freeze interrupted FLUSH, so the remaining flush cycles resume afterwards
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    ret_d       = ret_q;
    case (state_q)
      RUN, FLUSH:
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
          ret_d      = state_q == FLUSH;
        end else if (bus.branch_taken_EX) begin
          state_d     = REDIRECT_ST;
          flush_cnt_d = FLUSH_RELOAD;
        end else if (state_q == FLUSH) begin
          flush_cnt_d = flush_cnt_q - 8'd1;
          state_d     = flush_cnt_q == 8'd1 ? RUN : FLUSH;
        end
      MEM_WAIT:
        if (bus.dmem_ready || wait_cnt_q == TIMEOUT) begin
          state_d    = (bus.dmem_ready && ret_q) ? FLUSH : RUN;
          ret_d      = 1'b0;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      default: state_d = RUN;
    endcase
  end
  // outputs are held low while rst is asserted regardless of the inputs
  always_comb begin
    frozen              = !rst && (state_q == MEM_WAIT || mem_stall);
    redirect            = !rst && !frozen && bus.branch_taken_EX;
    bubble              = !rst && !frozen && !bus.branch_taken_EX && state_q == RUN && load_use;
    bus.stall_IF        = frozen || bubble;
    bus.stall_ID        = frozen || bubble;
    bus.stall_EX        = frozen;
    bus.stall_M         = frozen;
    bus.flush_IF        = redirect || (!rst && !frozen && state_q == FLUSH);
    bus.flush_EX        = redirect || bubble;
    bus.mem_timeout_err = !rst && state_q == MEM_WAIT && !bus.dmem_ready && wait_cnt_q == TIMEOUT;
    bus.state_o         = state_q;
  end
`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (bus.stall_IF),
    .redirect_i (redirect),
    .stall_cnt_o(bus.perf_stall_cnt),
    .flush_cnt_o(bus.perf_flush_cnt)
  );
`endif
endmodule
